// File: rtl/example_arb_pkg.sv
// Shared types and constants for the round-robin arbiter in front of the shared
// 4-bit `example` unit.
package example_arb_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Saturating increment used by the per-requester grant counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/example_arbiter_if.sv
// Bundle of requester, datapath and response signals around example_arbiter.
// slave = arbiter side, master = surrounding logic (requesters, `example`, consumer).
interface example_arbiter_if
    import example_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]       REQ;
    logic [NREQ*WIDTH-1:0] REQ_A;
    logic [NREQ*WIDTH-1:0] REQ_B;
    logic [NREQ-1:0]       GNT;
    logic [WIDTH-1:0]      EX_A;
    logic [WIDTH-1:0]      EX_B;
    logic [WIDTH-1:0]      EX_C;
    logic                  RSP_VALID;
    logic                  RSP_READY;
    logic [WIDTH-1:0]      RSP_C;
    logic [IDX_W-1:0]      RSP_ID;
    logic                  BUSY;
    logic [NREQ*CNT_W-1:0] GNT_CNT;

    modport slave (
        input  REQ, REQ_A, REQ_B, EX_C, RSP_READY,
        output GNT, EX_A, EX_B, RSP_VALID, RSP_C, RSP_ID, BUSY, GNT_CNT
    );

    modport master (
        output REQ, REQ_A, REQ_B, EX_C, RSP_READY,
        input  GNT, EX_A, EX_B, RSP_VALID, RSP_C, RSP_ID, BUSY, GNT_CNT
    );

endinterface

// File: rtl/example_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping
// modulo NREQ.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_valid
);

    int unsigned pos;

    // Scanning from the farthest offset down to 0 leaves the nearest hit last.
    always_comb begin
        pos     = 0;
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % NREQ;
            if (req[pos]) begin
                win_idx = IDX_W'(pos);
            end
        end
    end

    assign any_valid  = |req;
    assign win_onehot = any_valid ? (NREQ'(1) << win_idx) : '0;

endmodule

// File: rtl/example_arbiter.sv
// Round-robin arbiter/sequencer sharing one `example` unit among NREQ requesters.
// Optional per-requester grant counters are built when EXAMPLE_ARB_STATS_EN is defined.
module example_arbiter
    import example_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         CLK,
    input  logic         RST,
    example_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NREQ);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] id_q, id_d;
    logic [WIDTH-1:0] ex_a_q, ex_a_d;
    logic [WIDTH-1:0] ex_b_q, ex_b_d;
    logic [WIDTH-1:0] rsp_c_q, rsp_c_d;

    logic             grant_en;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             any_valid;

    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
        assign op_a[gi] = bus.REQ_A[gi*WIDTH +: WIDTH];
        assign op_b[gi] = bus.REQ_B[gi*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (bus.REQ),
        .ptr        (ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any_valid  (any_valid)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        ex_a_d   = ex_a_q;
        ex_b_d   = ex_b_q;
        rsp_c_d  = rsp_c_q;
        grant_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                rsp_c_d = bus.EX_C;
                state_d = RESP;
            end
            RESP: begin
                // Completing a response and granting the next winner share one cycle.
                if (bus.RSP_READY) begin
                    if (any_valid) begin
                        grant_en = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_en) begin
            ptr_d  = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            id_d   = win_idx;
            ex_a_d = op_a[win_idx];
            ex_b_d = op_b[win_idx];
        end
    end

    // A reset cycle never grants, so the held request is re-arbitrated from 0.
    assign gnt = (grant_en && !RST) ? win_onehot : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            ex_a_q  <= '0;
            ex_b_q  <= '0;
            rsp_c_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            ex_a_q  <= ex_a_d;
            ex_b_q  <= ex_b_d;
            rsp_c_q <= rsp_c_d;
        end
    end

    logic [NREQ*CNT_W-1:0] gnt_cnt;

`ifdef EXAMPLE_ARB_STATS_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (gnt[gi]) begin
                cnt_d = sat_inc(cnt_q);
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign gnt_cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
`else
    assign gnt_cnt = '0;
`endif

    assign bus.GNT       = gnt;
    assign bus.EX_A      = ex_a_q;
    assign bus.EX_B      = ex_b_q;
    assign bus.RSP_VALID = (state_q == RESP);
    assign bus.RSP_C     = rsp_c_q;
    assign bus.RSP_ID    = id_q;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.GNT_CNT   = gnt_cnt;

endmodule
